// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 8:1 mux scan controller.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } scan_state_e;

  // Counter reload value for a given settle time; 0 when no settle cycles are used.
  function automatic logic [CNT_W-1:0] settle_load(input int unsigned settle);
    return (settle == 0) ? CNT_W'(0) : CNT_W'(settle - 1);
  endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// Loadable down-counter timing the select settle window; stops at zero.
module scan_dwell_counter
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  // Load wins over decrement so a reload on the sampling cycle starts a fresh window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 8:1 mux select, samples each channel after a settle window and
// presents the assembled byte on a valid/ready handshake.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont,
  input  logic              y_in,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = settle_load(SETTLE);
  localparam scan_state_e      FIRST_ST    = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_CH - 1);

  scan_state_e       r_state;
  scan_state_e       w_next;
  logic [SEL_W-1:0]  r_sel;
  logic [NUM_CH-1:0] r_shift;
  logic [NUM_CH-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_busy;

  logic w_cnt_load;
  logic w_cnt_en;
  logic w_cnt_zero_c;
  logic w_sample;
  logic w_last;
  logic w_accept;

  scan_dwell_counter u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (SETTLE_LOAD),
    .i_en       (w_cnt_en),
    .o_zero_c   (w_cnt_zero_c)
  );

  assign w_last   = (r_sel == LAST_SEL);
  assign w_accept = (r_state == ST_HOLD) && r_data_valid && data_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    w_sample   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next     = FIRST_ST;
          w_cnt_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_cnt_zero_c) begin
          w_next = ST_SAMPLE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_SAMPLE: begin
        w_sample = 1'b1;
        if (w_last) begin
          w_next = ST_HOLD;
        end else begin
          w_next     = FIRST_ST;
          w_cnt_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_accept) begin
          if (cont) begin
            w_next     = FIRST_ST;
            w_cnt_load = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: the last channel's sample goes straight into the output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      if (w_sample) begin
        r_shift[r_sel] <= y_in;
        if (w_last) begin
          r_data_out   <= {y_in, r_shift[NUM_CH-2:0]};
          r_data_valid <= 1'b1;
        end else begin
          r_sel <= r_sel + SEL_W'(1);
        end
      end
      if (w_accept) begin
        r_sel        <= '0;
        r_shift      <= '0;
        r_data_valid <= 1'b0;
      end
    end
  end

  assign sel        = r_sel;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized self-checking bench for mux_scan_ctrl; expected select/valid timing
// comes from arithmetic on the channel period, expected words from the mux pattern.
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int unsigned S = 2;
  localparam int unsigned P = S + 1;
  localparam int unsigned L = NUM_CH * P;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       data_ready = 1'b0;
  logic       y_in;
  logic [2:0] sel;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic [7:0] r_mux = 8'h00;

  logic       z_start = 1'b0;
  logic       z_cont = 1'b0;
  logic       z_ready = 1'b0;
  logic       z_y_in;
  logic [2:0] z_sel;
  logic [7:0] z_data_out;
  logic       z_valid;
  logic       z_busy;
  logic [7:0] z_mux = 8'h00;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign y_in   = r_mux[sel];
  assign z_y_in = z_mux[z_sel];

  mux_scan_ctrl #(.SETTLE(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont       (cont),
    .y_in       (y_in),
    .sel        (sel),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy)
  );

  mux_scan_ctrl #(.SETTLE(0)) dut_z (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (z_start),
    .cont       (z_cont),
    .y_in       (z_y_in),
    .sel        (z_sel),
    .data_out   (z_data_out),
    .data_valid (z_valid),
    .data_ready (z_ready),
    .busy       (z_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full word: channel n occupies edges k+n*P+1 .. k+(n+1)*P, valid at k+L.
  task automatic scan_word(input logic [7:0] pat, input bit use_start, input int ready_delay,
                           input bit cont_v, input int glitch_t);
    r_mux = pat;
    if (use_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    check_eq("sel_at_start", 32'(sel), 32'(0));
    check_eq("busy_at_start", 32'(busy), 32'(1));
    check_eq("valid_at_start", 32'(data_valid), 32'(0));
    for (int t = 1; t < int'(L); t++) begin
      cont  = 1'($urandom);
      start = (t == glitch_t);
      step();
      start = 1'b0;
      check_eq("sel_seq", 32'(sel), 32'(t / int'(P)));
      check_eq("valid_early", 32'(data_valid), 32'(0));
      check_eq("busy_scan", 32'(busy), 32'(1));
    end
    step();
    check_eq("valid_rise", 32'(data_valid), 32'(1));
    check_eq("word", 32'(data_out), 32'(pat));
    check_eq("sel_hold", 32'(sel), 32'(NUM_CH - 1));
    for (int d = 0; d < ready_delay; d++) begin
      cont = 1'($urandom);
      step();
      check_eq("stall_valid", 32'(data_valid), 32'(1));
      check_eq("stall_word", 32'(data_out), 32'(pat));
      check_eq("stall_sel", 32'(sel), 32'(NUM_CH - 1));
    end
    data_ready = 1'b1;
    cont       = cont_v;
    step();
    data_ready = 1'b0;
    check_eq("valid_fall", 32'(data_valid), 32'(0));
    check_eq("sel_after_hs", 32'(sel), 32'(0));
    check_eq("busy_after_hs", 32'(busy), 32'(cont_v));
    check_eq("word_kept", 32'(data_out), 32'(pat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit   prev_cont;
    bit   cv;
    int   gl;
    logic [7:0] pat;
    logic [7:0] zpat;

    repeat (3) step();
    check_eq("rst_sel", 32'(sel), 32'(0));
    check_eq("rst_valid", 32'(data_valid), 32'(0));
    check_eq("rst_word", 32'(data_out), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("z_rst_busy", 32'(z_busy), 32'(0));
    rst_n = 1'b1;
    step();

    // Asynchronous reset mid-SETTLE on channel 3.
    r_mux = 8'h5A;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check_eq("pre_rst_sel", 32'(sel), 32'(3));
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_sel", 32'(sel), 32'(0));
    check_eq("arst_busy", 32'(busy), 32'(0));
    check_eq("arst_valid", 32'(data_valid), 32'(0));
    check_eq("arst_word", 32'(data_out), 32'(0));
    step();
    step();
    rst_n = 1'b1;
    step();
    check_eq("idle_busy", 32'(busy), 32'(0));

    scan_word(8'hA6, 1'b1, 0, 1'b0, -1);
    repeat (3) step();
    check_eq("idle_after_single", 32'(busy), 32'(0));
    check_eq("idle_word", 32'(data_out), 32'hA6);

    scan_word(8'hA6, 1'b1, 10, 1'b0, -1);

    scan_word(8'hA6, 1'b1, 0, 1'b1, -1);
    scan_word(8'h3C, 1'b0, 0, 1'b0, -1);

    scan_word(8'h96, 1'b1, 0, 1'b0, 4 * int'(P) + 1);

    prev_cont = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pat = 8'($urandom);
      cv  = (i == 7) ? 1'b0 : 1'($urandom);
      gl  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, L - 1)) : -1;
      scan_word(pat, !prev_cont, int'($urandom_range(0, 4)), cv, gl);
      prev_cont = cv;
      if (!cv) repeat ($urandom_range(0, 3)) step();
    end

    // SETTLE = 0: one channel per cycle.
    zpat    = 8'($urandom);
    z_mux   = zpat;
    z_start = 1'b1;
    step();
    z_start = 1'b0;
    check_eq("z_sel0", 32'(z_sel), 32'(0));
    for (int t = 1; t < int'(NUM_CH); t++) begin
      step();
      check_eq("z_sel_seq", 32'(z_sel), 32'(t));
      check_eq("z_valid_early", 32'(z_valid), 32'(0));
    end
    step();
    check_eq("z_valid_rise", 32'(z_valid), 32'(1));
    check_eq("z_word", 32'(z_data_out), 32'(zpat));
    z_ready = 1'b1;
    step();
    z_ready = 1'b0;
    check_eq("z_valid_fall", 32'(z_valid), 32'(0));
    check_eq("z_busy_idle", 32'(z_busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
